// File: rtl/ctx_mem_pkg.sv
// Shared types and address-range helper for the context memory responder.
// No logic state; combinational helper only.
// No flow control here; see ctx_mem_responder.
package ctx_mem_pkg;

  localparam int CTX_WORD_W = 32;
  localparam int CTX_ADDR_W = 32;

  typedef logic [CTX_WORD_W-1:0] ctx_word_t;
  typedef logic [CTX_ADDR_W-1:0] ctx_addr_t;

  typedef struct packed {
    logic      valid;
    ctx_word_t data;
  } ctx_rd_stage_t;

  // 33-bit compare so a window near the top of the address space cannot wrap
  function automatic logic ctx_in_range(input ctx_addr_t addr,
                                        input ctx_addr_t base,
                                        input int unsigned depth);
    logic [CTX_ADDR_W:0] a;
    logic [CTX_ADDR_W:0] lo;
    logic [CTX_ADDR_W:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'(depth) << 2);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/ctx_mem_rd_pipe.sv
// Read response shift register of ctx_rd_stage_t entries.
// Latency READ_LATENCY cycles from issue_stage to resp_stage.
// No backpressure; data only advances with a valid so the output holds between responses.
module ctx_mem_rd_pipe
  import ctx_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  ctx_rd_stage_t issue_stage,
  output ctx_rd_stage_t resp_stage
);

  ctx_rd_stage_t stage_q [READ_LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < READ_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0].valid <= issue_stage.valid;
      if (issue_stage.valid) stage_q[0].data <= issue_stage.data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_q[i].valid <= stage_q[i-1].valid;
        if (stage_q[i-1].valid) stage_q[i].data <= stage_q[i-1].data;
      end
    end
  end

  assign resp_stage = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/ctx_mem_responder.sv
// Context-store SRAM endpoint: word writes plus pipelined reads; CTX_MEM_STATS_EN adds counters.
// Read response exactly READ_LATENCY cycles after request; error pulse one cycle after access.
// Never stalls: writes and reads are accepted every cycle, no grant or ready.
module ctx_mem_responder
  import ctx_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0010_0000,
  parameter int          DEPTH        = 1024,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ctx_mem_wr_en_i,
  input  logic [31:0] ctx_mem_wr_addr_i,
  input  logic [31:0] ctx_mem_wr_data_i,
  input  logic        ctx_mem_rd_rq_valid_i,
  input  logic [31:0] ctx_mem_rd_rq_addr_i,
  output logic        ctx_mem_rd_resp_valid_o,
  output logic [31:0] ctx_mem_rd_data_o,
`ifdef CTX_MEM_STATS_EN
  output logic [31:0] stat_wr_cnt_o,
  output logic [31:0] stat_rd_cnt_o,
  output logic [31:0] stat_err_cnt_o,
`endif
  output logic        ctx_mem_err_o
);

  localparam int IDX_W = $clog2(DEPTH);

  ctx_word_t        mem [DEPTH];
  ctx_addr_t        wr_off;
  ctx_addr_t        rd_off;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_in;
  logic             rd_in;
  logic             mem_we;
  logic             wr_err;
  logic             rd_err;
  logic             err_q;
  ctx_rd_stage_t    issue_stage;
  ctx_rd_stage_t    resp_stage;

  assign wr_off = ctx_mem_wr_addr_i - BASE_ADDR;
  assign rd_off = ctx_mem_rd_rq_addr_i - BASE_ADDR;
  assign wr_idx = wr_off[IDX_W+1:2];
  assign rd_idx = rd_off[IDX_W+1:2];
  assign wr_in  = ctx_in_range(ctx_mem_wr_addr_i, BASE_ADDR, DEPTH);
  assign rd_in  = ctx_in_range(ctx_mem_rd_rq_addr_i, BASE_ADDR, DEPTH);
  assign mem_we = ctx_mem_wr_en_i && wr_in;
  assign wr_err = ctx_mem_wr_en_i && (!wr_in || (ctx_mem_wr_addr_i[1:0] != 2'b00));
  assign rd_err = ctx_mem_rd_rq_valid_i && (!rd_in || (ctx_mem_rd_rq_addr_i[1:0] != 2'b00));

  // Array contents survive reset; the reset branch only blocks writes while rst_ni is low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
    end else if (mem_we) begin
      mem[wr_idx] <= ctx_mem_wr_data_i;
    end
  end

  // Write-first: a same-cycle write to the read index is forwarded into stage 0
  always_comb begin
    issue_stage.valid = ctx_mem_rd_rq_valid_i;
    issue_stage.data  = ERR_DATA;
    if (rd_in) begin
      issue_stage.data = (mem_we && (wr_idx == rd_idx)) ? ctx_mem_wr_data_i : mem[rd_idx];
    end
  end

  ctx_mem_rd_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .issue_stage (issue_stage),
    .resp_stage  (resp_stage)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= wr_err || rd_err;
  end

  assign ctx_mem_rd_resp_valid_o = resp_stage.valid;
  assign ctx_mem_rd_data_o       = resp_stage.data;
  assign ctx_mem_err_o           = err_q;

`ifdef CTX_MEM_STATS_EN
  logic [31:0] stat_wr_cnt_q;
  logic [31:0] stat_rd_cnt_q;
  logic [31:0] stat_err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_wr_cnt_q  <= '0;
      stat_rd_cnt_q  <= '0;
      stat_err_cnt_q <= '0;
    end else begin
      if (mem_we && (stat_wr_cnt_q != '1))                  stat_wr_cnt_q  <= stat_wr_cnt_q + 32'd1;
      if (ctx_mem_rd_rq_valid_i && (stat_rd_cnt_q != '1))   stat_rd_cnt_q  <= stat_rd_cnt_q + 32'd1;
      if ((wr_err || rd_err) && (stat_err_cnt_q != '1))     stat_err_cnt_q <= stat_err_cnt_q + 32'd1;
    end
  end

  assign stat_wr_cnt_o  = stat_wr_cnt_q;
  assign stat_rd_cnt_o  = stat_rd_cnt_q;
  assign stat_err_cnt_o = stat_err_cnt_q;
`endif

endmodule

// File: tb/tb_ctx_mem_responder.sv
// Directed bench for ctx_mem_responder: one instance at READ_LATENCY=1, one at 3, shared stimulus.
module tb_ctx_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_vld;
  logic [31:0] rd_addr;
  logic        v1, v3, e1, e3;
  logic [31:0] d1, d3;
`ifdef CTX_MEM_STATS_EN
  logic [31:0] swr1, srd1, serr1, swr3, srd3, serr3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctx_mem_responder #(.READ_LATENCY(1)) dut1 (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .ctx_mem_wr_en_i         (wr_en),
    .ctx_mem_wr_addr_i       (wr_addr),
    .ctx_mem_wr_data_i       (wr_data),
    .ctx_mem_rd_rq_valid_i   (rd_vld),
    .ctx_mem_rd_rq_addr_i    (rd_addr),
    .ctx_mem_rd_resp_valid_o (v1),
    .ctx_mem_rd_data_o       (d1),
`ifdef CTX_MEM_STATS_EN
    .stat_wr_cnt_o           (swr1),
    .stat_rd_cnt_o           (srd1),
    .stat_err_cnt_o          (serr1),
`endif
    .ctx_mem_err_o           (e1)
  );

  ctx_mem_responder #(.READ_LATENCY(3)) dut3 (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .ctx_mem_wr_en_i         (wr_en),
    .ctx_mem_wr_addr_i       (wr_addr),
    .ctx_mem_wr_data_i       (wr_data),
    .ctx_mem_rd_rq_valid_i   (rd_vld),
    .ctx_mem_rd_rq_addr_i    (rd_addr),
    .ctx_mem_rd_resp_valid_o (v3),
    .ctx_mem_rd_data_o       (d3),
`ifdef CTX_MEM_STATS_EN
    .stat_wr_cnt_o           (swr3),
    .stat_rd_cnt_o           (srd3),
    .stat_err_cnt_o          (serr3),
`endif
    .ctx_mem_err_o           (e3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access cycle followed by the checks for both latencies
  task automatic xact(input string tag, input logic we, input logic [31:0] wa,
                      input logic [31:0] wd, input logic re, input logic [31:0] ra,
                      input logic [31:0] exp_d, input logic exp_e);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_vld = re; rd_addr = ra;
    step();
    wr_en = 1'b0; rd_vld = 1'b0;
    chk({tag, "/v1"}, 32'(v1), 32'(re));
    if (re) chk({tag, "/d1"}, d1, exp_d);
    chk({tag, "/e1"}, 32'(e1), 32'(exp_e));
    chk({tag, "/e3"}, 32'(e3), 32'(exp_e));
    step();
    chk({tag, "/v3_early"}, 32'(v3), 32'd0);
    chk({tag, "/e1_pulse"}, 32'(e1), 32'd0);
    step();
    chk({tag, "/v3"}, 32'(v3), 32'(re));
    if (re) chk({tag, "/d3"}, d3, exp_d);
    step();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_vld = 1'b0; rd_addr = '0;
    step(); step(); step();
    chk("rst/v1", 32'(v1), 32'd0);
    chk("rst/d1", d1, 32'd0);
    chk("rst/e1", 32'(e1), 32'd0);
    chk("rst/v3", 32'(v3), 32'd0);
    chk("rst/d3", d3, 32'd0);
    rst_n = 1'b1;
    step();

    xact("wr10", 1'b1, 32'h0010_0010, 32'hCAFE_0001, 1'b0, 32'h0, 32'h0, 1'b0);
    xact("rd10", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0010_0010, 32'hCAFE_0001, 1'b0);

    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 32'h0010_0100 + 32'(i * 4); wr_data = 32'hA500_0000 + 32'(i);
      step();
    end
    wr_en = 1'b0;
    chk("burst_wr/e1", 32'(e1), 32'd0);
    for (int k = 0; k < 35; k++) begin
      rd_vld = (k < 32);
      rd_addr = 32'h0010_0100 + 32'(k * 4);
      step();
      chk($sformatf("burst/v1_%0d", k), 32'(v1), 32'(k < 32));
      if (k < 32) chk($sformatf("burst/d1_%0d", k), d1, 32'hA500_0000 + 32'(k));
      chk($sformatf("burst/v3_%0d", k), 32'(v3), 32'((k >= 2) && (k < 34)));
      if ((k >= 2) && (k < 34)) chk($sformatf("burst/d3_%0d", k), d3, 32'hA500_0000 + 32'(k - 2));
    end
    rd_vld = 1'b0;
    chk("burst/d1_hold", d1, 32'hA500_001F);

    xact("fwd", 1'b1, 32'h0010_0020, 32'h1234_5678, 1'b1, 32'h0010_0020, 32'h1234_5678, 1'b0);

    // Write lands one cycle after the read issued: response keeps the old word
    rd_vld = 1'b1; rd_addr = 32'h0010_0020;
    step();
    rd_vld = 1'b0; wr_en = 1'b1; wr_addr = 32'h0010_0020; wr_data = 32'h0000_0055;
    chk("late_wr/d1", d1, 32'h1234_5678);
    step();
    wr_en = 1'b0;
    chk("late_wr/v3_early", 32'(v3), 32'd0);
    step();
    chk("late_wr/v3", 32'(v3), 32'd1);
    chk("late_wr/d3", d3, 32'h1234_5678);
    step();
    xact("late_wr_chk", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0010_0020, 32'h0000_0055, 1'b0);

    xact("rd_oor", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0010_1000, 32'hDEAD_BEEF, 1'b1);
    xact("wr_oor", 1'b1, 32'h000F_FFFC, 32'h7777_7777, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("wr_last", 1'b1, 32'h0010_0FFC, 32'h0BAD_F00D, 1'b0, 32'h0, 32'h0, 1'b0);
    xact("rd_last", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0010_0FFC, 32'h0BAD_F00D, 1'b0);
    xact("rd_mis", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0010_0012, 32'hCAFE_0001, 1'b1);
    xact("dual_err", 1'b1, 32'h000F_FFFC, 32'h1, 1'b1, 32'h0010_1000, 32'hDEAD_BEEF, 1'b1);

`ifdef CTX_MEM_STATS_EN
    chk("stat/wr1", swr1, 32'd36);
    chk("stat/rd1", srd1, 32'd40);
    chk("stat/err1", serr1, 32'd4);
    chk("stat/rd3", srd3, 32'd40);
    force dut1.stat_rd_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut1.stat_rd_cnt_q;
    xact("stat_sat", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0010_0010, 32'hCAFE_0001, 1'b0);
    chk("stat/rd1_sat", srd1, 32'hFFFF_FFFF);
    chk("stat/rd3_inc", srd3, 32'd41);
`endif

    // Reset one cycle after a latency-3 read issues; that read must never respond
    rd_vld = 1'b1; rd_addr = 32'h0010_0010;
    step();
    rd_vld = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mid_rst/v1", 32'(v1), 32'd0);
    chk("mid_rst/d1", d1, 32'd0);
    chk("mid_rst/v3", 32'(v3), 32'd0);
    chk("mid_rst/d3", d3, 32'd0);
    chk("mid_rst/e1", 32'(e1), 32'd0);
    wr_en = 1'b1; wr_addr = 32'h0010_0010; wr_data = 32'hFFFF_FFFF;
    step();
    step();
    wr_en = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("post_rst/v1_%0d", k), 32'(v1), 32'd0);
      chk($sformatf("post_rst/v3_%0d", k), 32'(v3), 32'd0);
    end
`ifdef CTX_MEM_STATS_EN
    chk("stat/rd1_rst", srd1, 32'd0);
    chk("stat/wr1_rst", swr1, 32'd0);
`endif
    xact("rst_wr_ignored", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0010_0010, 32'hCAFE_0001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctx_mem_responder.md
Name: ctx_mem_responder

Overview:
- Target-side endpoint of the RTOS-unit context memory interface.
- Accepts context-save writes and context-restore read requests from the RTOS unit's memory port.
- Holds them in a word-addressed SRAM array and returns read data over a fixed-latency, fully pipelined response channel.
- Sits beside the core in simulation wrappers and FPGA tops as the dedicated context store; it does not share the core data bus.

Parameters:
- BASE_ADDR, 32'h0010_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH, 1024, number of 32-bit words; power of two, at least 2.
- READ_LATENCY, 1, cycles from an accepted read request to its response; range 1..8.
- ERR_DATA, 32'hDEAD_BEEF, data returned for an out-of-range read.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- ctx_mem_wr_en_i  in  1  write strobe; one word per cycle; no grant.
- ctx_mem_wr_addr_i  in  32  write byte address.
- ctx_mem_wr_data_i  in  32  write data.
- ctx_mem_rd_rq_valid_i  in  1  read request strobe; always accepted.
- ctx_mem_rd_rq_addr_i  in  32  read byte address.
- ctx_mem_rd_resp_valid_o  out  1  read response valid, single-cycle pulse per request.
- ctx_mem_rd_data_o  out  32  read response data.
- ctx_mem_err_o  out  1  one-cycle pulse on any out-of-range or misaligned access.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Outputs under reset: ctx_mem_rd_resp_valid_o=0, ctx_mem_rd_data_o=0, ctx_mem_err_o=0. Read pipeline valids are cleared. Memory array is not reset.
- Address decode: offset = addr - BASE_ADDR; index = offset[log2(DEPTH)+1:2].
  - In range means BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH, evaluated with 33-bit arithmetic so no wrap-around.
  - Misaligned (addr[1:0] != 0): access still performed at the truncated word; ctx_mem_err_o pulses.
- Writes: when ctx_mem_wr_en_i=1 and in range, mem[index] is updated at the clock edge. Out-of-range writes are dropped and ctx_mem_err_o pulses the next cycle.
- Reads: a request is accepted every cycle ctx_mem_rd_rq_valid_i=1, with no stall.
  - Array read happens in the issue cycle (stage 0). Data then shifts through READ_LATENCY-1 register stages.
  - ctx_mem_rd_resp_valid_o rises exactly READ_LATENCY cycles after the request cycle.
  - Back-to-back requests produce back-to-back responses in request order.
- Out-of-range read: response still produced at the same latency, with data=ERR_DATA. ctx_mem_err_o pulses the next cycle.
- Same-cycle write and read to the same index: write-first; the read returns the new data via forwarding.
- Write to an index after the read was issued: the response carries the old value sampled at issue.
- Simultaneous write error and read error in one cycle: a single ctx_mem_err_o pulse.
- ctx_mem_rd_data_o holds its last value while valid=0. It is only meaningful while valid=1.
- Reset mid-operation: in-flight reads are discarded, no response is emitted, and writes in the reset cycle are ignored.

Optional Feature:
- Macro: CTX_MEM_STATS_EN.
- When defined:
  - Adds outputs stat_wr_cnt_o[31:0], stat_rd_cnt_o[31:0] and stat_err_cnt_o[31:0].
  - Counters count accepted writes, accepted reads and error events respectively.
  - Counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined: these ports and counters are absent; no other behaviour changes.

Decomposition:
- Package ctx_mem_pkg:
  - CTX_WORD_W=32, CTX_ADDR_W=32.
  - typedef ctx_word_t.
  - struct ctx_rd_stage_t {valid, data}.
  - function ctx_in_range().
- Sub-module ctx_mem_rd_pipe: parameterised READ_LATENCY shift register of ctx_rd_stage_t, with async reset clearing valids.
- The array and decode stay in the top.

Test Plan:
- Reset sequence: assert rst_ni=0 mid-stream, release -> all outputs 0; a read issued 1 cycle before reset never responds.
- Write 32'hCAFE_0001 to 32'h0010_0010, read same address next cycle with LATENCY=1 -> resp_valid one cycle after request, data 32'hCAFE_0001, err_o=0.
- Back-to-back reads of 32 consecutive words (context restore burst) with LATENCY=3 -> 32 contiguous valid pulses starting 3 cycles after the first request, data in order.
- Same-cycle write 32'h1234_5678 and read at 32'h0010_0020 -> response 32'h1234_5678.
- Read of 32'h0010_1000 (first address past the array) -> data 32'hDEAD_BEEF, err_o pulse.
- Write to 32'h000F_FFFC -> dropped, err_o pulse.
- Misaligned read of 32'h0010_0012 -> returns word at 32'h0010_0010, err_o pulse.
- Under CTX_MEM_STATS_EN: after the above -> counters match the exact access and error totals; force stat_rd_cnt to 32'hFFFF_FFFF then do one more read -> counter stays at 32'hFFFF_FFFF.
